ex_mem_wb_pipe_reg: RTL and testbench
=====================================

Name: ex_mem_wb_pipe_reg

Overview:
Parametrised EX->MEM->WB pipeline register for the N-issue integer pipeline.
- Replaces the fixed dual-lane version.
- Adds per-lane valid bits, branch-lane kill of any younger lane, global flush, and bubble insertion into WB while MEM is stalled by the dcache.
- Sits between the EX-stage ALUs and the MEM/WB register-file write ports.

Parameters:
LANES, 2, issue width; lane 0 is oldest.
DW, 32, datapath width.
AW, 5, register-file address width.
MTW, 3, memory-access-type width.
SELW, 6, writeback-mux select width.

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
mem_stall  in  1  dcache stall; holds the MEM stage.
flush  in  1  global flush (exception/ertn); kills EX and MEM contents.
ex_valid  in  LANES  per-lane instruction valid.
ex_br_valid  in  1  a lane in EX redirects (mispredict).
ex_br_lane  in  $clog2(LANES)  index of the redirecting lane.
ex_result  in  LANES*DW  ALU results; lane i occupies [i*DW +: DW].
ex_rf_we  in  LANES  register-file write enables.
ex_rf_waddr  in  LANES*AW  register-file write addresses.
ex_mem_type  in  LANES*MTW  access types; 0 = none.
ex_wb_sel  in  LANES*SELW  writeback-mux selects.
ex_ready  out  1  equals !mem_stall; EX may advance.
mem_valid, mem_rf_we  out  LANES  MEM-stage valid / write enable.
mem_result  out  LANES*DW
mem_rf_waddr  out  LANES*AW
mem_mem_type  out  LANES*MTW
mem_wb_sel  out  LANES*SELW
mem_rf_wdata  in  LANES*DW  final MEM-stage writeback data.
wb_valid, wb_rf_we  out  LANES
wb_result, wb_rf_wdata  out  LANES*DW
wb_rf_waddr  out  LANES*AW

Behaviour:
- Reset (async, rstn low): every output register is cleared to 0, which is the bubble value.
- Kill mask: lane i is killed when ex_br_valid && i > ex_br_lane. The redirecting lane itself is never killed.
- A bubble lane has valid=0, rf_we=0, result=0, mem_type=0, wb_sel=0. rf_waddr is still copied.
- EX->MEM, evaluated on each posedge, in priority order:
  1. flush=1: all MEM lanes load a bubble, regardless of mem_stall.
  2. mem_stall=1: all MEM registers hold their values.
  3. Otherwise, lane i loads the EX fields, with valid = ex_valid[i] & !kill[i] and rf_we = ex_rf_we[i] & that valid. A lane that is not valid loads a bubble.
- MEM->WB, evaluated on each posedge:
  - flush=1 or mem_stall=1: all WB lanes load valid=0 and rf_we=0. Data and address fields hold their previous values, so a stall never causes a duplicate register write.
  - Otherwise, WB copies mem_valid, mem_rf_we, mem_result and mem_rf_waddr, and captures mem_rf_wdata.
- Latency: 1 cycle EX->MEM and 1 cycle MEM->WB when there is no stall.
- mem_rf_we never exceeds mem_valid (invariant). The same holds for wb_rf_we and wb_valid.
- Stall deasserting in the same cycle as ex_br_valid: the kill applies to the EX contents captured on that edge.
- ex_br_valid while mem_stall=1: ignored, because nothing is captured. EX must hold its redirect until ex_ready.
- Reset asserted mid-stall: all outputs clear immediately (async). No state survives reset.
- ex_br_lane >= LANES: kill mask is all zero (no lane is killed).

Decomposition:
- Package pipe_pkg holds:
  - the bubble constants (MEM_TYPE_NONE=0, WB_SEL_NONE=0);
  - the function kill_mask(br_valid, br_lane), which returns LANES bits;
  - the lane index width localparam.
- Sub-module pipe_lane_slot holds one lane's MEM and WB registers with load/hold/bubble controls. It is instantiated LANES times by a generate loop.
- The top level computes the kill mask, applies flush/stall priority, and handles port slicing.

Test Plan:
1. Reset release, then LANES=2, both lanes valid, results 0x11/0x22, we=1, waddr 3/4 -> mem_* equal the inputs after 1 cycle; wb_rf_we=2'b11 and waddr 3/4 after 2 cycles.
2. ex_br_valid=1, ex_br_lane=0, both lanes valid -> mem_valid=2'b01, mem_rf_we[1]=0, mem_result lane1=0, mem_wb_sel lane1=0.
3. mem_stall held high for 3 cycles with a valid MEM pair -> MEM registers are unchanged; wb_rf_we=0 on all 3 edges; on release, WB writes exactly once.
4. flush asserted together with mem_stall=1 and EX valid -> mem_valid=0 and wb_valid=0 on the next edge; ex_ready stays 0.
5. LANES=4 build, ex_br_lane=1 -> lanes 2 and 3 are killed; mem_valid=4'b0011 (all four lanes valid in EX).
6. rstn pulsed low mid-stall with valid data -> all outputs are 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the EX->MEM->WB pipeline register:
//            bubble encodings, the lane index width and the branch kill-mask
//            helper.
// Contents : MAX_LANES, LANE_IDX_W, MEM_TYPE_NONE, WB_SEL_NONE, kill_mask()
// Revision : 1.0 - initial N-issue version
// ============================================================================
package pipe_pkg;

  // Widest issue width the kill-mask helper supports.
  localparam int unsigned MAX_LANES  = 8;
  // Width of a lane index for the widest supported issue width.
  localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

  // Bubble encodings: "no memory access" and "no writeback source".
  localparam int unsigned MEM_TYPE_NONE = 0;
  localparam int unsigned WB_SEL_NONE   = 0;

  // Returns one bit per lane (bits >= lanes are always 0). A lane is killed
  // when it is younger than the redirecting lane. The index carries one spare
  // bit so that an out-of-range lane number can be represented; such an index
  // kills nothing.
  function automatic logic [MAX_LANES-1:0] kill_mask(
    input logic                  br_valid,
    input logic [LANE_IDX_W:0]   br_lane,
    input int unsigned           lanes
  );
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (br_valid && (32'(br_lane) < lanes) && (i < lanes) && (i > 32'(br_lane))) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_lane_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_lane_slot
// Purpose  : One issue lane of the EX->MEM->WB pipeline register. Holds the
//            lane's MEM-stage and WB-stage registers.
// Ports    : clk, rstn          - clock, async active-low reset
//            mem_load_i         - MEM registers capture this edge
//            mem_bubble_i       - captured MEM contents are forced to a bubble
//            ex_*_i             - EX-stage fields (ex_valid_i already killed)
//            wb_bubble_i        - WB loads valid=0/we=0 and holds its data
//            mem_rf_wdata_i     - final MEM writeback data, captured into WB
//            mem_*_o / wb_*_o   - registered stage outputs
// Revision : 1.0 - initial N-issue version
// ============================================================================
module pipe_lane_slot
  import pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int MTW  = 3,
  parameter int SELW = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mem_load_i,
  input  logic            mem_bubble_i,
  input  logic            ex_valid_i,
  input  logic            ex_rf_we_i,
  input  logic [DW-1:0]   ex_result_i,
  input  logic [AW-1:0]   ex_rf_waddr_i,
  input  logic [MTW-1:0]  ex_mem_type_i,
  input  logic [SELW-1:0] ex_wb_sel_i,
  input  logic            wb_bubble_i,
  input  logic [DW-1:0]   mem_rf_wdata_i,
  output logic            mem_valid_o,
  output logic            mem_rf_we_o,
  output logic [DW-1:0]   mem_result_o,
  output logic [AW-1:0]   mem_rf_waddr_o,
  output logic [MTW-1:0]  mem_mem_type_o,
  output logic [SELW-1:0] mem_wb_sel_o,
  output logic            wb_valid_o,
  output logic            wb_rf_we_o,
  output logic [DW-1:0]   wb_result_o,
  output logic [DW-1:0]   wb_rf_wdata_o,
  output logic [AW-1:0]   wb_rf_waddr_o
);

  logic            mem_valid_q,    mem_valid_d;
  logic            mem_rf_we_q,    mem_rf_we_d;
  logic [DW-1:0]   mem_result_q,   mem_result_d;
  logic [AW-1:0]   mem_rf_waddr_q, mem_rf_waddr_d;
  logic [MTW-1:0]  mem_mem_type_q, mem_mem_type_d;
  logic [SELW-1:0] mem_wb_sel_q,   mem_wb_sel_d;
  logic            wb_valid_q,     wb_valid_d;
  logic            wb_rf_we_q,     wb_rf_we_d;
  logic [DW-1:0]   wb_result_q,    wb_result_d;
  logic [DW-1:0]   wb_rf_wdata_q,  wb_rf_wdata_d;
  logic [AW-1:0]   wb_rf_waddr_q,  wb_rf_waddr_d;
  logic            live;

  always_comb begin
    live           = ex_valid_i & ~mem_bubble_i;
    mem_valid_d    = mem_valid_q;
    mem_rf_we_d    = mem_rf_we_q;
    mem_result_d   = mem_result_q;
    mem_rf_waddr_d = mem_rf_waddr_q;
    mem_mem_type_d = mem_mem_type_q;
    mem_wb_sel_d   = mem_wb_sel_q;
    if (mem_load_i) begin
      // A non-live lane is a bubble; its write address is still carried.
      mem_valid_d    = live;
      mem_rf_we_d    = live & ex_rf_we_i;
      mem_result_d   = live ? ex_result_i   : '0;
      mem_mem_type_d = live ? ex_mem_type_i : MTW'(MEM_TYPE_NONE);
      mem_wb_sel_d   = live ? ex_wb_sel_i   : SELW'(WB_SEL_NONE);
      mem_rf_waddr_d = ex_rf_waddr_i;
    end

    // A WB bubble only drops valid/we; holding the data keeps a stalled
    // instruction from being written twice.
    wb_valid_d    = wb_bubble_i ? 1'b0 : mem_valid_q;
    wb_rf_we_d    = wb_bubble_i ? 1'b0 : mem_rf_we_q;
    wb_result_d   = wb_result_q;
    wb_rf_wdata_d = wb_rf_wdata_q;
    wb_rf_waddr_d = wb_rf_waddr_q;
    if (!wb_bubble_i) begin
      wb_result_d   = mem_result_q;
      wb_rf_wdata_d = mem_rf_wdata_i;
      wb_rf_waddr_d = mem_rf_waddr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid_q    <= 1'b0;
      mem_rf_we_q    <= 1'b0;
      mem_result_q   <= '0;
      mem_rf_waddr_q <= '0;
      mem_mem_type_q <= '0;
      mem_wb_sel_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_rf_we_q     <= 1'b0;
      wb_result_q    <= '0;
      wb_rf_wdata_q  <= '0;
      wb_rf_waddr_q  <= '0;
    end else begin
      mem_valid_q    <= mem_valid_d;
      mem_rf_we_q    <= mem_rf_we_d;
      mem_result_q   <= mem_result_d;
      mem_rf_waddr_q <= mem_rf_waddr_d;
      mem_mem_type_q <= mem_mem_type_d;
      mem_wb_sel_q   <= mem_wb_sel_d;
      wb_valid_q     <= wb_valid_d;
      wb_rf_we_q     <= wb_rf_we_d;
      wb_result_q    <= wb_result_d;
      wb_rf_wdata_q  <= wb_rf_wdata_d;
      wb_rf_waddr_q  <= wb_rf_waddr_d;
    end
  end

  assign mem_valid_o    = mem_valid_q;
  assign mem_rf_we_o    = mem_rf_we_q;
  assign mem_result_o   = mem_result_q;
  assign mem_rf_waddr_o = mem_rf_waddr_q;
  assign mem_mem_type_o = mem_mem_type_q;
  assign mem_wb_sel_o   = mem_wb_sel_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rf_we_o     = wb_rf_we_q;
  assign wb_result_o    = wb_result_q;
  assign wb_rf_wdata_o  = wb_rf_wdata_q;
  assign wb_rf_waddr_o  = wb_rf_waddr_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_wb_pipe_reg
// Purpose  : Parametrised EX->MEM->WB pipeline register for the N-issue
//            integer pipeline. Per-lane valid, branch kill of younger lanes,
//            global flush and WB bubble insertion while MEM is stalled.
// Ports    : clk, rstn               - clock, async active-low reset
//            mem_stall, flush        - dcache stall / global flush
//            ex_*                    - EX-stage lane fields (lane 0 oldest)
//            ex_br_valid/ex_br_lane  - redirect and redirecting lane
//            ex_ready                - EX may advance (= !mem_stall)
//            mem_*                   - MEM-stage registered outputs
//            mem_rf_wdata            - final MEM writeback data (input)
//            wb_*                    - WB-stage registered outputs
// Revision : 1.0 - initial N-issue version (LANES <= MAX_LANES)
// ============================================================================
module ex_mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int MTW   = 3,
  parameter int SELW  = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mem_stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         ex_valid,
  input  logic                     ex_br_valid,
  input  logic [$clog2(LANES)-1:0] ex_br_lane,
  input  logic [LANES*DW-1:0]      ex_result,
  input  logic [LANES-1:0]         ex_rf_we,
  input  logic [LANES*AW-1:0]      ex_rf_waddr,
  input  logic [LANES*MTW-1:0]     ex_mem_type,
  input  logic [LANES*SELW-1:0]    ex_wb_sel,
  output logic                     ex_ready,
  output logic [LANES-1:0]         mem_valid,
  output logic [LANES-1:0]         mem_rf_we,
  output logic [LANES*DW-1:0]      mem_result,
  output logic [LANES*AW-1:0]      mem_rf_waddr,
  output logic [LANES*MTW-1:0]     mem_mem_type,
  output logic [LANES*SELW-1:0]    mem_wb_sel,
  input  logic [LANES*DW-1:0]      mem_rf_wdata,
  output logic [LANES-1:0]         wb_valid,
  output logic [LANES-1:0]         wb_rf_we,
  output logic [LANES*DW-1:0]      wb_result,
  output logic [LANES*DW-1:0]      wb_rf_wdata,
  output logic [LANES*AW-1:0]      wb_rf_waddr
);

  logic [MAX_LANES-1:0] w_kill;
  logic                 w_unused_kill;
  logic                 w_mem_load;
  logic                 w_mem_bubble;
  logic                 w_wb_bubble;

  assign w_kill = kill_mask(ex_br_valid, (LANE_IDX_W+1)'(ex_br_lane), LANES);
  // Bits above LANES are always zero.
  assign w_unused_kill = &{1'b0, w_kill};

  // Flush wins over stall: MEM captures a bubble even while stalled.
  assign w_mem_load   = flush | ~mem_stall;
  assign w_mem_bubble = flush;
  assign w_wb_bubble  = flush | mem_stall;
  assign ex_ready     = ~mem_stall;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pipe_lane_slot #(
      .DW   (DW),
      .AW   (AW),
      .MTW  (MTW),
      .SELW (SELW)
    ) u_slot (
      .clk            (clk),
      .rstn           (rstn),
      .mem_load_i     (w_mem_load),
      .mem_bubble_i   (w_mem_bubble),
      .ex_valid_i     (ex_valid[g] & ~w_kill[g]),
      .ex_rf_we_i     (ex_rf_we[g]),
      .ex_result_i    (ex_result[g*DW +: DW]),
      .ex_rf_waddr_i  (ex_rf_waddr[g*AW +: AW]),
      .ex_mem_type_i  (ex_mem_type[g*MTW +: MTW]),
      .ex_wb_sel_i    (ex_wb_sel[g*SELW +: SELW]),
      .wb_bubble_i    (w_wb_bubble),
      .mem_rf_wdata_i (mem_rf_wdata[g*DW +: DW]),
      .mem_valid_o    (mem_valid[g]),
      .mem_rf_we_o    (mem_rf_we[g]),
      .mem_result_o   (mem_result[g*DW +: DW]),
      .mem_rf_waddr_o (mem_rf_waddr[g*AW +: AW]),
      .mem_mem_type_o (mem_mem_type[g*MTW +: MTW]),
      .mem_wb_sel_o   (mem_wb_sel[g*SELW +: SELW]),
      .wb_valid_o     (wb_valid[g]),
      .wb_rf_we_o     (wb_rf_we[g]),
      .wb_result_o    (wb_result[g*DW +: DW]),
      .wb_rf_wdata_o  (wb_rf_wdata[g*DW +: DW]),
      .wb_rf_waddr_o  (wb_rf_waddr[g*AW +: AW])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_wb_pipe_reg
// Purpose  : Self-checking bench for ex_mem_wb_pipe_reg: a 2-lane and a 4-lane
//            instance share one stimulus; a lane-level model is compared every
//            cycle and directed literal expectations pin key cases.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_wb_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, mem_stall, flush, br_valid, br_lane2;
  logic [1:0]   br_lane4;
  logic [3:0]   exv, exwe;
  logic [127:0] exres, wdat;
  logic [19:0]  exwa;
  logic [11:0]  exmt;
  logic [23:0]  exsel;

  int errors = 0;
  int checks = 0;

  // 2-lane instance outputs
  logic         d2_rdy;
  logic [1:0]   d2_mv, d2_mwe, d2_wv, d2_wwe;
  logic [63:0]  d2_mres, d2_wres, d2_wdt;
  logic [9:0]   d2_mwa, d2_wwa;
  logic [5:0]   d2_mmt;
  logic [11:0]  d2_msel;
  // 4-lane instance outputs
  logic         d4_rdy;
  logic [3:0]   d4_mv, d4_mwe, d4_wv, d4_wwe;
  logic [127:0] d4_mres, d4_wres, d4_wdt;
  logic [19:0]  d4_mwa, d4_wwa;
  logic [11:0]  d4_mmt;
  logic [23:0]  d4_msel;

  ex_mem_wb_pipe_reg #(.LANES(2)) dut2 (
    .clk(clk), .rstn(rstn), .mem_stall(mem_stall), .flush(flush),
    .ex_valid(exv[1:0]), .ex_br_valid(br_valid), .ex_br_lane(br_lane2),
    .ex_result(exres[63:0]), .ex_rf_we(exwe[1:0]), .ex_rf_waddr(exwa[9:0]),
    .ex_mem_type(exmt[5:0]), .ex_wb_sel(exsel[11:0]), .ex_ready(d2_rdy),
    .mem_valid(d2_mv), .mem_rf_we(d2_mwe), .mem_result(d2_mres),
    .mem_rf_waddr(d2_mwa), .mem_mem_type(d2_mmt), .mem_wb_sel(d2_msel),
    .mem_rf_wdata(wdat[63:0]), .wb_valid(d2_wv), .wb_rf_we(d2_wwe),
    .wb_result(d2_wres), .wb_rf_wdata(d2_wdt), .wb_rf_waddr(d2_wwa)
  );

  ex_mem_wb_pipe_reg #(.LANES(4)) dut4 (
    .clk(clk), .rstn(rstn), .mem_stall(mem_stall), .flush(flush),
    .ex_valid(exv), .ex_br_valid(br_valid), .ex_br_lane(br_lane4),
    .ex_result(exres), .ex_rf_we(exwe), .ex_rf_waddr(exwa),
    .ex_mem_type(exmt), .ex_wb_sel(exsel), .ex_ready(d4_rdy),
    .mem_valid(d4_mv), .mem_rf_we(d4_mwe), .mem_result(d4_mres),
    .mem_rf_waddr(d4_mwa), .mem_mem_type(d4_mmt), .mem_wb_sel(d4_msel),
    .mem_rf_wdata(wdat), .wb_valid(d4_wv), .wb_rf_we(d4_wwe),
    .wb_result(d4_wres), .wb_rf_wdata(d4_wdt), .wb_rf_waddr(d4_wwa)
  );

  // ---------------- lane-level model (index 0: 2-lane, 1: 4-lane) ---------
  logic        mv  [2][4];
  logic        mwe [2][4];
  logic [31:0] mres[2][4];
  logic [4:0]  mwa [2][4];
  logic [2:0]  mmt [2][4];
  logic [5:0]  msel[2][4];
  logic        wv  [2][4];
  logic        wwe [2][4];
  logic [31:0] wres[2][4];
  logic [31:0] wdt [2][4];
  logic [4:0]  wwa [2][4];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 0; mwe[k][i] = 0; mres[k][i] = 0; mwa[k][i] = 0;
        mmt[k][i] = 0; msel[k][i] = 0; wv[k][i] = 0; wwe[k][i] = 0;
        wres[k][i] = 0; wdt[k][i] = 0; wwa[k][i] = 0;
      end
    end
  endtask

  task automatic model_step(input int k, input int n, input int brl);
    bit killed, live;
    for (int i = 0; i < n; i++) begin
      // WB takes the MEM contents present before this edge
      if (flush || mem_stall) begin
        wv[k][i] = 0; wwe[k][i] = 0;
      end else begin
        wv[k][i] = mv[k][i]; wwe[k][i] = mwe[k][i]; wres[k][i] = mres[k][i];
        wwa[k][i] = mwa[k][i]; wdt[k][i] = wdat[i*32 +: 32];
      end
      if (flush) begin
        mv[k][i] = 0; mwe[k][i] = 0; mres[k][i] = 0; mmt[k][i] = 0; msel[k][i] = 0;
        mwa[k][i] = exwa[i*5 +: 5];
      end else if (!mem_stall) begin
        killed = br_valid && (brl < n) && (i > brl);
        live   = exv[i] && !killed;
        mv[k][i]   = live;
        mwe[k][i]  = live && exwe[i];
        mres[k][i] = live ? exres[i*32 +: 32] : 32'd0;
        mmt[k][i]  = live ? exmt[i*3 +: 3] : 3'd0;
        msel[k][i] = live ? exsel[i*6 +: 6] : 6'd0;
        mwa[k][i]  = exwa[i*5 +: 5];
      end
    end
  endtask

  always @(negedge rstn) model_clear();
  always @(posedge clk) begin
    if (!rstn) model_clear();
    else begin
      model_step(0, 2, int'(br_lane2));
      model_step(1, 4, int'(br_lane4));
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int k, input int n, input logic rdy,
                           input logic [3:0] a_mv, input logic [3:0] a_mwe,
                           input logic [127:0] a_mres, input logic [19:0] a_mwa,
                           input logic [11:0] a_mmt, input logic [23:0] a_msel,
                           input logic [3:0] a_wv, input logic [3:0] a_wwe,
                           input logic [127:0] a_wres, input logic [127:0] a_wdt,
                           input logic [19:0] a_wwa);
    logic [3:0] e_mv, e_mwe, e_wv, e_wwe;
    logic [127:0] e_mres, e_wres, e_wdt;
    logic [19:0] e_mwa, e_wwa;
    logic [11:0] e_mmt;
    logic [23:0] e_msel;
    e_mv = 0; e_mwe = 0; e_wv = 0; e_wwe = 0; e_mres = 0; e_wres = 0; e_wdt = 0;
    e_mwa = 0; e_wwa = 0; e_mmt = 0; e_msel = 0;
    for (int i = 0; i < n; i++) begin
      e_mv[i] = mv[k][i]; e_mwe[i] = mwe[k][i]; e_mres[i*32 +: 32] = mres[k][i];
      e_mwa[i*5 +: 5] = mwa[k][i]; e_mmt[i*3 +: 3] = mmt[k][i]; e_msel[i*6 +: 6] = msel[k][i];
      e_wv[i] = wv[k][i]; e_wwe[i] = wwe[k][i]; e_wres[i*32 +: 32] = wres[k][i];
      e_wdt[i*32 +: 32] = wdt[k][i]; e_wwa[i*5 +: 5] = wwa[k][i];
    end
    chk({tag, ".ex_ready"}, 128'(rdy), 128'(!mem_stall));
    chk({tag, ".mem_valid"}, 128'(a_mv), 128'(e_mv));
    chk({tag, ".mem_rf_we"}, 128'(a_mwe), 128'(e_mwe));
    chk({tag, ".mem_result"}, a_mres, e_mres);
    chk({tag, ".mem_rf_waddr"}, 128'(a_mwa), 128'(e_mwa));
    chk({tag, ".mem_mem_type"}, 128'(a_mmt), 128'(e_mmt));
    chk({tag, ".mem_wb_sel"}, 128'(a_msel), 128'(e_msel));
    chk({tag, ".wb_valid"}, 128'(a_wv), 128'(e_wv));
    chk({tag, ".wb_rf_we"}, 128'(a_wwe), 128'(e_wwe));
    chk({tag, ".wb_result"}, a_wres, e_wres);
    chk({tag, ".wb_rf_wdata"}, a_wdt, e_wdt);
    chk({tag, ".wb_rf_waddr"}, 128'(a_wwa), 128'(e_wwa));
    chk({tag, ".inv_mem_we_le_valid"}, 128'(a_mwe & ~a_mv), 128'(0));
    chk({tag, ".inv_wb_we_le_valid"}, 128'(a_wwe & ~a_wv), 128'(0));
  endtask

  // Outputs are only ever updated at posedge (or async reset); check at negedge.
  always @(negedge clk) begin
    check_dut("d2", 0, 2, d2_rdy, {2'b0, d2_mv}, {2'b0, d2_mwe}, {64'h0, d2_mres},
              {10'h0, d2_mwa}, {6'h0, d2_mmt}, {12'h0, d2_msel}, {2'b0, d2_wv},
              {2'b0, d2_wwe}, {64'h0, d2_wres}, {64'h0, d2_wdt}, {10'h0, d2_wwa});
    check_dut("d4", 1, 4, d4_rdy, d4_mv, d4_mwe, d4_mres, d4_mwa, d4_mmt, d4_msel,
              d4_wv, d4_wwe, d4_wres, d4_wdt, d4_wwa);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 0; mem_stall = 0; flush = 0; br_valid = 0; br_lane2 = 0; br_lane4 = 0;
    exv = 0; exwe = 0; exres = 0; wdat = 0; exwa = 0; exmt = 0; exsel = 0;
    repeat (2) tick();
    chk("reset.mem_valid", 128'(d2_mv), 128'(0));
    chk("reset.wb_rf_we", 128'(d2_wwe), 128'(0));
    chk("reset.mem_result", 128'(d2_mres), 128'(0));
    rstn = 1;

    // 1: straight-through, two valid lanes
    exv = 4'b0011; exwe = 4'b0011;
    exres = {64'h0, 32'h22, 32'h11}; exwa = {10'd0, 5'd4, 5'd3};
    exmt = {6'd0, 3'd2, 3'd1}; exsel = {12'd0, 6'd5, 6'd9};
    wdat = {64'h0, 32'hBB, 32'hAA};
    tick();
    chk("t1.mem_result", 128'(d2_mres), 128'({32'h22, 32'h11}));
    chk("t1.mem_rf_waddr", 128'(d2_mwa), 128'({5'd4, 5'd3}));
    chk("t1.mem_valid", 128'(d2_mv), 128'(2'b11));
    chk("t1.mem_mem_type", 128'(d2_mmt), 128'({3'd2, 3'd1}));
    exv = 0;
    tick();
    chk("t1.wb_rf_we", 128'(d2_wwe), 128'(2'b11));
    chk("t1.wb_rf_waddr", 128'(d2_wwa), 128'({5'd4, 5'd3}));
    chk("t1.wb_rf_wdata", 128'(d2_wdt), 128'({32'hBB, 32'hAA}));

    // 2: redirect from lane 0 kills every younger lane
    exv = 4'hF; exwe = 4'hF;
    exres = {32'h44, 32'h33, 32'h22, 32'h11};
    br_valid = 1; br_lane2 = 0; br_lane4 = 0;
    tick();
    chk("t2.mem_valid", 128'(d2_mv), 128'(2'b01));
    chk("t2.mem_rf_we1", 128'(d2_mwe[1]), 128'(0));
    chk("t2.mem_result1", 128'(d2_mres[63:32]), 128'(0));
    chk("t2.mem_wb_sel1", 128'(d2_msel[11:6]), 128'(0));
    chk("t2.mem_rf_waddr1", 128'(d2_mwa[9:5]), 128'(5'd4));
    chk("t2.d4_mem_valid", 128'(d4_mv), 128'(4'b0001));
    br_valid = 0;

    // 3: three-cycle stall with a valid MEM pair; branch during stall ignored
    exv = 4'b0011; exres = {64'h0, 32'h44, 32'h33}; exwa = {10'd0, 5'd6, 5'd5};
    wdat = {64'h0, 32'hDD, 32'hCC};
    tick();
    mem_stall = 1; exres = {64'h0, 32'h66, 32'h55}; exwa = {10'd0, 5'd8, 5'd7};
    br_valid = 1; br_lane2 = 0; br_lane4 = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3.hold_mem_result", 128'(d2_mres), 128'({32'h44, 32'h33}));
      chk("t3.hold_mem_valid", 128'(d2_mv), 128'(2'b11));
      chk("t3.stall_wb_rf_we", 128'(d2_wwe), 128'(0));
    end
    mem_stall = 0; br_valid = 0; exv = 0;
    tick();
    chk("t3.release_wb_rf_we", 128'(d2_wwe), 128'(2'b11));
    chk("t3.release_wb_waddr", 128'(d2_wwa), 128'({5'd6, 5'd5}));
    chk("t3.release_wb_wdata", 128'(d2_wdt), 128'({32'hDD, 32'hCC}));
    tick();
    chk("t3.single_write", 128'(d2_wwe), 128'(0));

    // 4: flush together with stall
    exv = 4'b0011;
    tick();
    mem_stall = 1; flush = 1;
    tick();
    chk("t4.mem_valid", 128'(d2_mv), 128'(0));
    chk("t4.wb_valid", 128'(d2_wv), 128'(0));
    chk("t4.ex_ready", 128'(d2_rdy), 128'(0));
    chk("t4.d4_mem_valid", 128'(d4_mv), 128'(0));
    flush = 0; mem_stall = 0;

    // 5: 4-lane kill patterns and a redirect landing on stall release
    exv = 4'hF; br_valid = 1; br_lane4 = 2'd1; br_lane2 = 1'b1;
    tick();
    chk("t5.d4_mem_valid_lane1", 128'(d4_mv), 128'(4'b0011));
    chk("t5.d4_mem_rf_we_lane1", 128'(d4_mwe), 128'(4'b0011));
    chk("t5.d2_mem_valid_lane1", 128'(d2_mv), 128'(2'b11));
    br_lane4 = 2'd3;
    tick();
    chk("t5.d4_mem_valid_lane3", 128'(d4_mv), 128'(4'b1111));
    mem_stall = 1; br_lane4 = 2'd0; br_lane2 = 1'b0;
    tick();
    chk("t5.d4_stall_ignores_br", 128'(d4_mv), 128'(4'b1111));
    mem_stall = 0;
    tick();
    chk("t5.d4_release_kill", 128'(d4_mv), 128'(4'b0001));
    chk("t5.d2_release_kill", 128'(d2_mv), 128'(2'b01));
    br_valid = 0;

    // 6: asynchronous reset in the middle of a stall
    exv = 4'b0011;
    tick();
    mem_stall = 1;
    tick();
    rstn = 0;
    #2;
    chk("t6.mem_valid", 128'(d2_mv), 128'(0));
    chk("t6.mem_result", 128'(d2_mres), 128'(0));
    chk("t6.wb_result", 128'(d2_wres), 128'(0));
    chk("t6.wb_rf_waddr", 128'(d2_wwa), 128'(0));
    chk("t6.d4_mem_valid", 128'(d4_mv), 128'(0));
    chk("t6.d4_mem_rf_waddr", 128'(d4_mwa), 128'(0));
    tick();
    rstn = 1; mem_stall = 0; exv = 0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
